// File: rtl/demux_pkg.sv
// rtl/demux_pkg.sv - shared constants and helpers for the demux32 router
package demux_pkg;

    localparam int   WIDTH_DEFAULT = 32;
    localparam logic SEL_A         = 1'b0;
    localparam logic SEL_B         = 1'b1;

    // Ceiling log2 for sizing pointers; returns 0 for values <= 1
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/demux32_router_chan_fifo.sv
// rtl/demux32_router_chan_fifo.sv - per-channel buffer with registered head word and delivery counter
module chan_fifo
    import demux_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT,
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             full,
    output logic [CNT_W-1:0] count
);

    localparam int AW = clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q, wr_d;
    logic [AW-1:0]    rd_q, rd_d;
    logic [AW:0]      occ_q, occ_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pop;

    assign out_valid = (occ_q != '0);
    assign full      = (occ_q == (AW+1)'(DEPTH));
    assign pop       = out_valid && pop_ready;
    assign out_data  = data_q;
    assign count     = cnt_q;

    // Next pointers/occupancy, and the word that will sit at the head next cycle
    always_comb begin
        wr_d   = wr_q;
        rd_d   = rd_q;
        occ_d  = occ_q;
        cnt_d  = cnt_q;
        data_d = data_q;
        if (push) begin
            wr_d = wr_q + 1'b1;
        end
        if (pop) begin
            rd_d  = rd_q + 1'b1;
            cnt_d = cnt_q + 1'b1;
        end
        if (push && !pop) begin
            occ_d = occ_q + 1'b1;
        end else if (pop && !push) begin
            occ_d = occ_q - 1'b1;
        end
        // The new head is the incoming word only when the buffer drains to it this cycle;
        // an empty buffer keeps presenting the last head word.
        if (occ_d != '0) begin
            data_d = (push && (wr_q == rd_d)) ? push_data : mem_q[rd_d];
        end
    end

    // Control and head register; reset discards all buffered words
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q   <= '0;
            rd_q   <= '0;
            occ_q  <= '0;
            cnt_q  <= '0;
            data_q <= '0;
        end else begin
            wr_q   <= wr_d;
            rd_q   <= rd_d;
            occ_q  <= occ_d;
            cnt_q  <= cnt_d;
            data_q <= data_d;
        end
    end

    // Storage array; contents are only meaningful under occupancy, so no reset
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_q] <= push_data;
        end
    end

endmodule

// File: rtl/demux32_router.sv
// rtl/demux32_router.sv - 1-to-2 demultiplexer steering words into two flow-controlled channels
module demux32_router
    import demux_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT,
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             in_sel,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             a_valid,
    output logic [WIDTH-1:0] a_data,
    input  logic             a_ready,
    output logic             b_valid,
    output logic [WIDTH-1:0] b_data,
    input  logic             b_ready,
    output logic [CNT_W-1:0] a_count,
    output logic [CNT_W-1:0] b_count
);

    logic a_full;
    logic b_full;
    logic accept;
    logic a_push;
    logic b_push;

    // Ready depends only on registered full flags, so a same-cycle pop never opens a slot
    assign in_ready = (in_sel == SEL_B) ? !b_full : !a_full;
    assign accept   = in_valid && in_ready;
    assign a_push   = accept && (in_sel == SEL_A);
    assign b_push   = accept && (in_sel == SEL_B);

    chan_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) u_chan_a (
        .clk       (clk),
        .rst       (rst),
        .push      (a_push),
        .push_data (in_data),
        .pop_ready (a_ready),
        .out_valid (a_valid),
        .out_data  (a_data),
        .full      (a_full),
        .count     (a_count)
    );

    chan_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) u_chan_b (
        .clk       (clk),
        .rst       (rst),
        .push      (b_push),
        .push_data (in_data),
        .pop_ready (b_ready),
        .out_valid (b_valid),
        .out_data  (b_data),
        .full      (b_full),
        .count     (b_count)
    );

endmodule

// File: doc/demux32_router.md
Name: demux32_router

Overview:
- Sequential 1-to-2 demultiplexer for the CPU datapath; the inverse of the 2:1 operand/result select.
- Accepts one 32-bit word per cycle with a 1-bit destination select and steers it into one of two buffered output channels (A for sel=0, B for sel=1).
- Each channel has independent valid/ready flow control, so a stalled consumer on one side does not block traffic to the other side.
- Sits between a result producer (ALU/load path) and two consumers (e.g. register-file write port and store/forward path).

Parameters:
- WIDTH, 32, data word width in bits.
- DEPTH, 2, entries per output channel buffer; power of 2, minimum 2.
- CNT_W, 16, width of the per-channel transfer counters.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  producer has a word this cycle.
- in_sel  input  1  destination: 0 = channel A, 1 = channel B.
- in_data  input  WIDTH  word to route.
- in_ready  output  1  word accepted when in_valid && in_ready.
- a_valid  output  1  channel A head word valid.
- a_data  output  WIDTH  channel A head word.
- a_ready  input  1  consumer A takes the head word when a_valid && a_ready.
- b_valid  output  1  channel B head word valid.
- b_data  output  WIDTH  channel B head word.
- b_ready  input  1  consumer B takes the head word when b_valid && b_ready.
- a_count  output  CNT_W  words delivered out of channel A.
- b_count  output  CNT_W  words delivered out of channel B.

Behaviour:
- Reset (async assert, synchronous release on clk): both buffers empty; a_valid=0, b_valid=0, a_data=0, b_data=0, a_count=0, b_count=0. in_ready reflects empty buffers (1) while reset is deasserted.
- in_ready = in_sel ? !b_full : !a_full. It is combinational on in_sel and on the registered full flags only; a same-cycle pop does not raise in_ready.
- in_sel and in_data are sampled only on an accepted transfer. in_sel has no effect when in_valid=0.
- Push: an accepted word is written to the tail of the selected buffer. The other buffer is untouched.
- Latency: a word accepted in cycle N appears at the head (x_valid=1) in cycle N+1 at the earliest. There is no combinational path from in_* to a_*/b_*.
- Pop: on x_valid && x_ready, the head entry is removed, the next entry (if any) is presented in the following cycle, and x_count increments by 1.
- x_count wraps modulo 2^CNT_W (0xFFFF -> 0x0000 at the default width).
- Simultaneous push and pop on the same channel: occupancy is unchanged and both operations take effect.
- Full condition: occupancy == DEPTH. Pushes are refused via in_ready=0, so data is never overwritten.
- Empty condition: x_valid=0. x_data holds its last value and is not cleared.
- Ordering: per-channel FIFO order is preserved. There is no ordering guarantee between channels.
- Read/write pointers are log2(DEPTH) bits with wrap-around, plus an occupancy counter of log2(DEPTH)+1 bits.
- Reset asserted mid-operation: all buffered words are discarded immediately, outputs return to their reset values, and counters clear.
- Behaviour when in_sel is X or Z and in_valid=1 is a protocol violation; the bench asserts against it.

Decomposition:
- Shared package demux_pkg:
  - WIDTH_DEFAULT = 32.
  - SEL_A = 1'b0 and SEL_B = 1'b1.
  - clog2 helper function.
- Sub-module chan_fifo (parameters WIDTH, DEPTH, CNT_W): push/pop FIFO with full/empty flags and delivered-word counter. Instantiated twice.
- Top level contains only select/ready steering.

Test Plan:
- Reset then in_valid=1, in_sel=0, in_data=0xDEADBEEF for one cycle, a_ready=1 -> next cycle a_valid=1, a_data=0xDEADBEEF, b_valid=0; following cycle a_count=1.
- Hold a_ready=0, push 0x1, 0x2 to A -> in_ready=0 with in_sel=0; then drive in_sel=1, data 0x3 -> accepted, b_data=0x3 next cycle, A contents unchanged.
- Continuous alternating sel 0/1/0/1 with data 0x10..0x13, both readys=1 -> A delivers 0x10, 0x12 and B delivers 0x11, 0x13; one word accepted per cycle, no stalls.
- A full with a_ready=1 for one cycle -> in_ready stays 0 that cycle (no bypass) and rises the next cycle; simultaneous push/pop at occupancy 1 keeps occupancy at 1.
- Preload a_count to 0xFFFF via 65535 pops, then one more pop -> a_count=0x0000.
- Assert rst asynchronously mid-cycle with both buffers holding data -> a_valid, b_valid and both counts go to 0 immediately; after release, the first push to B is delivered correctly.
